// File: rtl/icebreaker.sv
// ----------------------------------------------------------------------------
// icebreaker: LED pattern player that copies a pattern table from SPI flash
// into internal RAM after reset, then plays it on the board LEDs.
//
// Sequence after reset: WAKE (release flash from deep power-down, 0xAB),
// GAP1 (4 clk with CS# high), READ (0x03 + 24-bit address), LOAD
// (MEM_WORDS*4 bytes, little-endian words), PLAY (endless table playback).
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous active-high reset (ORed with power-on reset)
//   led1..led5    active-high LEDs, pattern bits 0..4
//   ledr_n        active-low red LED, pattern bit 5
//   ledg_n        active-low green LED, pattern bit 6
//   flash_csb     SPI flash chip select, active low
//   flash_clk     SPI flash clock, mode 0, clk/2
//   flash_io0     MOSI
//   flash_io1     MISO, never driven here
//   flash_io2/3   WP#/HOLD#, held high
// ----------------------------------------------------------------------------
module icebreaker #(
    parameter int unsigned MEM_WORDS  = 256,
    parameter logic [23:0] FLASH_ADDR = 24'h100000
) (
    input  logic clk,
    input  logic rst,
    output logic led1,
    output logic led2,
    output logic led3,
    output logic led4,
    output logic led5,
    output logic ledr_n,
    output logic ledg_n,
    output logic flash_csb,
    output logic flash_clk,
    inout  wire  flash_io0,
    inout  wire  flash_io1,
    inout  wire  flash_io2,
    inout  wire  flash_io3
);

    localparam int unsigned   AW       = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [AW-1:0] LAST_IDX = AW'(MEM_WORDS - 1);

    typedef enum logic [2:0] {StWake, StGap1, StRead, StLoad, StPlay} state_e;

    // Power-on reset: FPGA flops configure to zero, so bit 4 rises after
    // 16 clk edges and the internal reset is released.
    logic [4:0] por_cnt;
    logic       rst_int;

    always_ff @(posedge clk) begin
        if (!por_cnt[4]) begin
            por_cnt <= por_cnt + 1'b1;
        end
    end

    assign rst_int = rst | ~por_cnt[4];

    state_e        state_q, state_d;
    logic          csb_q, csb_d;
    logic          sclk_q, sclk_d;
    logic [31:0]   tx_q, tx_d;
    logic [5:0]    bit_cnt_q, bit_cnt_d;
    logic [1:0]    gap_cnt_q, gap_cnt_d;
    logic [6:0]    rx_q, rx_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [1:0]    byte_idx_q, byte_idx_d;
    logic [23:0]   word_q, word_d;
    logic [AW-1:0] word_idx_q, word_idx_d;
    logic          load_done_q, load_done_d;
    logic [AW-1:0] play_idx_q, play_idx_d;
    logic [23:0]   hold_q, hold_d;
    logic [6:0]    led_q, led_d;

    logic          mem_we;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem [MEM_WORDS];
    logic [31:0]   cur_word;
    logic [31:0]   first_word;
    logic [7:0]    rx_byte;
    logic          unused_bits;

    function automatic logic [AW-1:0] next_idx(input logic [AW-1:0] idx);
        return (idx == LAST_IDX) ? '0 : idx + 1'b1;
    endfunction

    assign rx_byte     = {rx_q, flash_io1};
    assign cur_word    = mem[play_idx_q];
    assign first_word  = mem[0];
    assign unused_bits = cur_word[7] ^ first_word[7];

    always_comb begin
        state_d     = state_q;
        csb_d       = csb_q;
        sclk_d      = sclk_q;
        tx_d        = tx_q;
        bit_cnt_d   = bit_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        rx_d        = rx_q;
        rx_bit_d    = rx_bit_q;
        byte_idx_d  = byte_idx_q;
        word_d      = word_q;
        word_idx_d  = word_idx_q;
        load_done_d = load_done_q;
        play_idx_d  = play_idx_q;
        hold_d      = hold_q;
        led_d       = led_q;
        mem_we      = 1'b0;
        mem_wdata   = {rx_byte, word_q};

        unique case (state_q)
            StWake: begin
                if (csb_q) begin
                    // First cycle out of reset: select flash with MSB on io0.
                    csb_d     = 1'b0;
                    tx_d      = {8'hAB, 24'h000000};
                    bit_cnt_d = '0;
                end else if (!sclk_q) begin
                    sclk_d    = 1'b1;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end else begin
                    sclk_d = 1'b0;
                    tx_d   = {tx_q[30:0], 1'b0};
                    if (bit_cnt_q == 6'd8) begin
                        csb_d     = 1'b1;
                        gap_cnt_d = '0;
                        state_d   = StGap1;
                    end
                end
            end

            StGap1: begin
                gap_cnt_d = gap_cnt_q + 1'b1;
                // CS# was high for this and the previous three cycles.
                if (gap_cnt_q == 2'd3) begin
                    csb_d     = 1'b0;
                    tx_d      = {8'h03, FLASH_ADDR};
                    bit_cnt_d = '0;
                    state_d   = StRead;
                end
            end

            StRead: begin
                if (!sclk_q) begin
                    sclk_d    = 1'b1;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end else begin
                    sclk_d = 1'b0;
                    tx_d   = {tx_q[30:0], 1'b0};
                    if (bit_cnt_q == 6'd32) begin
                        rx_bit_d    = '0;
                        byte_idx_d  = '0;
                        word_idx_d  = '0;
                        load_done_d = 1'b0;
                        state_d     = StLoad;
                    end
                end
            end

            StLoad: begin
                if (!sclk_q) begin
                    // io1 is sampled on the edge that raises flash_clk.
                    sclk_d   = 1'b1;
                    rx_d     = rx_byte[6:0];
                    rx_bit_d = rx_bit_q + 1'b1;
                    if (rx_bit_q == 3'd7) begin
                        byte_idx_d = byte_idx_q + 1'b1;
                        case (byte_idx_q)
                            2'd0: word_d[7:0]   = rx_byte;
                            2'd1: word_d[15:8]  = rx_byte;
                            2'd2: word_d[23:16] = rx_byte;
                            default: begin
                                mem_we     = 1'b1;
                                word_idx_d = next_idx(word_idx_q);
                                if (word_idx_q == LAST_IDX) begin
                                    load_done_d = 1'b1;
                                end
                            end
                        endcase
                    end
                end else begin
                    sclk_d = 1'b0;
                    tx_d   = {tx_q[30:0], 1'b0};
                    if (load_done_q) begin
                        csb_d      = 1'b1;
                        play_idx_d = '0;
                        hold_d     = '0;
                        state_d    = StPlay;
                    end
                end
            end

            StPlay: begin
                if (hold_q != '0) begin
                    hold_d = hold_q - 1'b1;
                end else if (cur_word[31:8] != '0) begin
                    led_d      = cur_word[6:0];
                    hold_d     = cur_word[31:8] - 1'b1;
                    play_idx_d = next_idx(play_idx_q);
                end else if (first_word[31:8] != '0) begin
                    // Zero hold marks end of table: jump straight to word 0
                    // so the previous pattern is not stretched.
                    led_d      = first_word[6:0];
                    hold_d     = first_word[31:8] - 1'b1;
                    play_idx_d = next_idx('0);
                end else begin
                    play_idx_d = '0;
                end
            end

            default: state_d = StWake;
        endcase
    end

    always_ff @(posedge clk or posedge rst_int) begin
        if (rst_int) begin
            state_q     <= StWake;
            csb_q       <= 1'b1;
            sclk_q      <= 1'b0;
            tx_q        <= '0;
            bit_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            rx_q        <= '0;
            rx_bit_q    <= '0;
            byte_idx_q  <= '0;
            word_q      <= '0;
            word_idx_q  <= '0;
            load_done_q <= 1'b0;
            play_idx_q  <= '0;
            hold_q      <= '0;
            led_q       <= '0;
        end else begin
            state_q     <= state_d;
            csb_q       <= csb_d;
            sclk_q      <= sclk_d;
            tx_q        <= tx_d;
            bit_cnt_q   <= bit_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            rx_q        <= rx_d;
            rx_bit_q    <= rx_bit_d;
            byte_idx_q  <= byte_idx_d;
            word_q      <= word_d;
            word_idx_q  <= word_idx_d;
            load_done_q <= load_done_d;
            play_idx_q  <= play_idx_d;
            hold_q      <= hold_d;
            led_q       <= led_d;
        end
    end

    // Pattern RAM, no reset needed: it is fully rewritten before PLAY.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[word_idx_q] <= mem_wdata;
        end
    end

    assign led1      = led_q[0];
    assign led2      = led_q[1];
    assign led3      = led_q[2];
    assign led4      = led_q[3];
    assign led5      = led_q[4];
    assign ledr_n    = ~led_q[5];
    assign ledg_n    = ~led_q[6];
    assign flash_csb = csb_q;
    assign flash_clk = sclk_q;
    assign flash_io0 = tx_q[31];
    assign flash_io2 = 1'b1;
    assign flash_io3 = 1'b1;

endmodule

// File: tb/tb_icebreaker.sv
// ----------------------------------------------------------------------------
// tb_icebreaker: bench for icebreaker with a behavioural SPI flash model and
// a table-driven LED playback reference.
// ----------------------------------------------------------------------------
module tb_icebreaker;

    localparam int unsigned MEM_WORDS  = 256;
    localparam logic [23:0] FLASH_ADDR = 24'h100000;
    localparam int          LOAD_RISES = 32 + MEM_WORDS * 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic led1, led2, led3, led4, led5, ledr_n, ledg_n;
    logic flash_csb, flash_clk;
    wire  flash_io0, flash_io1, flash_io2, flash_io3;
    logic io1_drv = 1'b0;

    assign flash_io1 = io1_drv;

    icebreaker #(
        .MEM_WORDS (MEM_WORDS),
        .FLASH_ADDR(FLASH_ADDR)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .led1     (led1),
        .led2     (led2),
        .led3     (led3),
        .led4     (led4),
        .led5     (led5),
        .ledr_n   (ledr_n),
        .ledg_n   (ledg_n),
        .flash_csb(flash_csb),
        .flash_clk(flash_clk),
        .flash_io0(flash_io0),
        .flash_io1(flash_io1),
        .flash_io2(flash_io2),
        .flash_io3(flash_io3)
    );

    always #5 clk = ~clk;

    int          n_checks  = 0;
    int          n_errors  = 0;
    logic [31:0] tbl [MEM_WORDS];
    int          rise_cnt  = 0;
    logic [31:0] cmd       = '0;
    int          win_rises[$];
    logic [31:0] win_cmd[$];
    int          gaps[$];
    int          hi_cnt    = 0;
    int          sclk_viol = 0;
    int          fk;
    logic [7:0]  fbyte;
    logic [6:0]  exp_q[$];

    // ---------------- flash model ----------------
    function automatic logic [7:0] flash_byte(input int b);
        logic [31:0] w;
        if (b >= int'(MEM_WORDS) * 4) return 8'hFF;
        w = tbl[b / 4];
        return w[8 * (b % 4) +: 8];
    endfunction

    always @(negedge flash_csb) begin
        gaps.push_back(hi_cnt);
        rise_cnt = 0;
        cmd      = '0;
    end

    always @(posedge flash_csb) begin
        win_rises.push_back(rise_cnt);
        win_cmd.push_back(cmd);
        hi_cnt = 0;
    end

    always @(posedge flash_clk) begin
        if (!flash_csb) begin
            if (rise_cnt < 32) cmd = {cmd[30:0], flash_io0};
            rise_cnt++;
        end
    end

    // Mode 0: flash shifts its next data bit out on the falling edge.
    always @(negedge flash_clk) begin
        if (!flash_csb && rise_cnt >= 32 && cmd[31:24] == 8'h03) begin
            fk      = rise_cnt - 32;
            fbyte   = flash_byte(int'(cmd[23:0] - FLASH_ADDR) + fk / 8);
            io1_drv = fbyte[7 - (fk % 8)];
        end
    end

    always @(negedge clk) begin
        if (flash_csb) hi_cnt++;
        if (flash_csb && flash_clk) sclk_viol++;
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] leds_now();
        return {~ledg_n, ~ledr_n, led5, led4, led3, led2, led1};
    endfunction

    task automatic finish_sim();
        check("sclk_low_while_csb_high", sclk_viol, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    endtask

    // Asserts rst between clock edges and checks the outputs react at once.
    task automatic pulse_reset(input string tag, input int cycles);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check({tag, "_rst_leds"}, leds_now(), 7'h00);
        check({tag, "_rst_csb"}, flash_csb, 1'b1);
        check({tag, "_rst_sclk"}, flash_clk, 1'b0);
        check({tag, "_rst_io0"}, flash_io0, 1'b0);
        repeat (cycles) @(posedge clk);
        #2 rst = 1'b0;
        win_rises.delete();
        win_cmd.delete();
        gaps.delete();
        hi_cnt = 0;
    endtask

    // Waits for WAKE and READ/LOAD windows to close, then checks their content.
    task automatic wait_load(input string tag);
        int t;
        int busy;
        t    = 0;
        busy = 0;
        while (win_rises.size() < 2 && t < 20000) begin
            if (leds_now() != 7'h00) busy++;
            @(negedge clk);
            t++;
        end
        if (win_rises.size() < 2) begin
            check({tag, "_load_timeout"}, 0, 1);
            finish_sim();
        end
        check({tag, "_wake_rises"}, win_rises[0], 8);
        check({tag, "_wake_byte"}, win_cmd[0], 32'h0000_00AB);
        check({tag, "_gap1_ge4"}, gaps[1] >= 4, 1);
        check({tag, "_read_cmd"}, win_cmd[1], {8'h03, FLASH_ADDR});
        check({tag, "_load_rises"}, win_rises[1], LOAD_RISES);
        check({tag, "_leds_idle_load"}, busy, 0);
    endtask

    // Reference playback: each word shows its pattern for H cycles; a zero
    // hold sends playback back to word 0; all-zero from word 0 holds LEDs.
    task automatic build_exp(input int n);
        int         idx;
        int         h;
        logic [6:0] cur;
        exp_q.delete();
        idx = 0;
        cur = 7'h00;
        while (exp_q.size() < n) begin
            h = int'(tbl[idx][31:8]);
            if (h == 0) begin
                if (idx == 0) exp_q.push_back(cur);
                else idx = 0;
            end else begin
                cur = tbl[idx][6:0];
                for (int j = 0; j < h && exp_q.size() < n; j++) exp_q.push_back(cur);
                idx = (idx + 1) % MEM_WORDS;
            end
        end
    endtask

    // Called on the first negedge after CS# rises at the end of LOAD.
    task automatic check_play(input string tag, input int n);
        logic [6:0] samp[$];
        int         off;
        for (int i = 0; i < n + 3; i++) begin
            samp.push_back(leds_now());
            @(negedge clk);
        end
        off = -1;
        for (int o = 0; o < 3; o++) begin
            if (off < 0 && samp[o] == exp_q[0] && samp[o+1] == exp_q[1] &&
                samp[o+2] == exp_q[2] && samp[o+3] == exp_q[3]) off = o;
        end
        check({tag, "_play_start"}, off >= 0, 1);
        if (off < 0) off = 1;
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_led[%0d]", tag, i), samp[off+i], exp_q[i]);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int t;
        int z;

        // A: three-word table from the datasheet example.
        for (int i = 0; i < int'(MEM_WORDS); i++) tbl[i] = $urandom();
        tbl[0] = 32'h0000_0A7F;
        tbl[1] = 32'h0000_0521;
        tbl[2] = 32'h0000_0000;
        pulse_reset("a", 20);
        wait_load("a");
        build_exp(40);
        check_play("a", 40);

        // B: every word H=1, pattern = index; checks wrap after word 255.
        for (int i = 0; i < int'(MEM_WORDS); i++) tbl[i] = {24'd1, 1'b0, 7'(i)};
        pulse_reset("b", 3);
        wait_load("b");
        build_exp(300);
        check_play("b", 300);

        // C: random table with a terminating zero word, reset pulse mid-LOAD.
        z = $urandom_range(5, 30);
        for (int i = 0; i < int'(MEM_WORDS); i++) begin
            tbl[i] = {24'($urandom_range(1, 6)), 1'($urandom()), 7'($urandom())};
        end
        tbl[0][0] = 1'b1;
        tbl[z]    = {24'h0, 8'($urandom())};
        pulse_reset("c", 2);
        t = 0;
        while (!(win_rises.size() >= 1 && rise_cnt > 2000) && t < 8000) begin
            @(negedge clk);
            t++;
        end
        check("c_reached_mid_load", t < 8000, 1);
        check("c_mid_load_csb", flash_csb, 1'b0);
        pulse_reset("c_mid", 1);
        wait_load("c");
        build_exp(200);
        check_play("c", 200);

        finish_sim();
    end

endmodule

// File: doc/icebreaker.md
ICEBREAKER -- requirements
Module: icebreaker

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 256, giving the number of 32-bit pattern words loaded from flash into internal RAM.
REQ-002 SHALL have parameter FLASH_ADDR, default 24'h100000, giving the flash byte address where the pattern table starts.
REQ-003 SHALL have one clock and an asynchronous, active-high reset.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 led1..led5  output  1 each  active-high LEDs (pattern bits 0..4).
REQ-007 ledr_n  output  1  active-low red LED (pattern bit 5).
REQ-008 ledg_n  output  1  active-low green LED (pattern bit 6).
REQ-009 flash_csb  output  1  SPI flash chip select, active low.
REQ-010 flash_clk  output  1  SPI flash clock, mode 0 (idles low).
REQ-011 flash_io0  inout  1  driven as MOSI.
REQ-012 flash_io1  inout  1  never driven (high-Z); sampled as MISO.
REQ-013 flash_io2, flash_io3  inout  1 each  always driven 1 (WP#/HOLD# inactive).

Function
REQ-014 rst SHALL be ORed with an internal power-on reset held 16 clk cycles after configuration, so the block starts with rst unconnected or low.
REQ-015 Sequencer states SHALL be WAKE, GAP1, READ, LOAD, PLAY, entered in that order after reset.
REQ-016 SPI clock SHALL be clk/2.
- io0 changes only while flash_clk is low.
- io1 is sampled on the clk edge that raises flash_clk.
- Bits are MSB first.
REQ-017 WAKE SHALL assert flash_csb low, shift byte 0xAB (8 flash_clk pulses), then deassert flash_csb.
REQ-018 GAP1 SHALL hold flash_csb high for 4 clk cycles.
REQ-019 READ SHALL assert flash_csb low and shift 0x03 followed by FLASH_ADDR[23:16], [15:8], [7:0].
REQ-020 LOAD SHALL clock in MEM_WORDS*4 bytes without releasing flash_csb.
- Bytes are packed little-endian: first byte goes to word[7:0].
- Words are written to RAM indices 0..MEM_WORDS-1.
- flash_csb is deasserted after the last byte.
REQ-021 flash_clk SHALL be low whenever flash_csb is high.
REQ-022 Pattern word format SHALL be:
- [6:0] LED pattern as {green, red, led5, led4, led3, led2, led1}.
- [7] ignored.
- [31:8] hold count H in clk cycles.
REQ-023 PLAY SHALL start at index 0, at most 2 clk after LOAD ends.
- If H != 0: pattern is driven to the LEDs for exactly H cycles, then the index advances.
- If H == 0: LEDs are unchanged and the index returns to 0 on the next cycle.
REQ-024 Index SHALL wrap from MEM_WORDS-1 to 0.
REQ-025 LED outputs SHALL be registered, with ledr_n = !bit5 and ledg_n = !bit6.
REQ-026 LEDs SHALL hold their reset values during WAKE, GAP1, READ and LOAD.
REQ-027 After LOAD, flash_csb SHALL stay high; flash is never accessed again until the next reset.

Reset
REQ-028 While reset is asserted (asynchronously, in any state) outputs SHALL be:
- led1..led5 = 0, ledr_n = 1, ledg_n = 1.
- flash_csb = 1, flash_clk = 0, flash_io0 = 0.
- state = WAKE, play index = 0, hold counter = 0.
REQ-029 Reset asserted mid-operation SHALL abort any SPI transfer immediately; after release the full WAKE/READ/LOAD sequence SHALL restart.
REQ-030 RAM contents SHALL NOT require clearing on reset.

Verification
REQ-031 Assert rst -> leds {ledg,ledr,led5..1} = 0000000 and flash_csb = 1 within the same cycle, without waiting for a clk edge.
REQ-032 Release rst -> first csb-low window carries exactly 8 flash_clk rising edges with io0 = 0xAB; csb then stays high at least 4 clk.
REQ-033 Second csb-low window -> io0 bits 0x03 0x10 0x00 0x00 followed by 8192 further flash_clk edges (MEM_WORDS = 256).
REQ-034 Flash at 0x100000: word0 = 0x00000A7F, word1 = 0x00000521, word2 = 0x00000000 ->
- leds = 1111111 for 10 cycles,
- then 0100001 for 5 cycles,
- then 1111111 again (restart from word 0).
REQ-035 Table with all 256 words H = 1 and pattern = index[6:0] -> leds step 0..127, 0..127 then wrap to index 0 after word 255.
REQ-036 Pulse rst for 1 cycle midway through LOAD -> csb goes high immediately, LEDs off, and the sequence restarts with 0xAB.
